// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Multi-cycle data-memory responder for MEM-stage load/store
//             requests. One request in flight at a time; busy stalls the
//             requester, data_valid pulses for one cycle on completion.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR_W  = 15,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
);

  localparam int         C_DEPTH     = 2 ** ADDR_W;
  localparam logic [1:0] C_ST_IDLE   = 2'd0;
  localparam logic [1:0] C_ST_WAIT   = 2'd1;
  localparam logic [1:0] C_ST_RESP   = 2'd2;
  // WAIT is entered with the number of extra edges still to burn before RESP.
  localparam logic [3:0] C_WAIT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);
  // With a single-cycle latency the accept edge is also the commit edge.
  localparam bit         C_DIRECT    = (LATENCY == 1);

  logic [1:0]        state_q,    state_d;
  logic [3:0]        count_q,    count_d;
  logic              req_wr_q,   req_wr_d;
  logic [ADDR_W-1:0] req_idx_q,  req_idx_d;
  logic [15:0]       req_data_q, req_data_d;
  logic [15:0]       data_out_q, data_out_d;

  // Storage array; deliberately has no reset.
  logic [15:0]       mem_q [C_DEPTH];

  logic              w_accept;
  logic              w_wait_done;
  logic              w_commit_go;
  logic              w_commit_wr;
  logic [ADDR_W-1:0] w_commit_idx;
  logic [15:0]       w_commit_data;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_in_idx;
  logic              unused_addr;
  logic              unused_req;

  // Byte address to word index; bit 0 and bits above ADDR_W alias away.
  assign w_in_idx    = addr[ADDR_W:1];
  assign unused_addr = ^addr;

  // A request is taken only when nothing is in flight (IDLE) or the previous
  // one is in its final response cycle (RESP).
  assign w_accept    = enable && ((state_q == C_ST_IDLE) || (state_q == C_ST_RESP));
  assign w_wait_done = (state_q == C_ST_WAIT) && (count_q == 4'd0);

  // Commit source: the live inputs when latency is one, else the captured request.
  generate
    if (C_DIRECT) begin : g_commit_direct
      assign w_commit_go   = w_accept;
      assign w_commit_wr   = wr;
      assign w_commit_idx  = w_in_idx;
      assign w_commit_data = data_in;
      assign unused_req    = ^{req_wr_q, req_idx_q, req_data_q};
    end else begin : g_commit_captured
      assign w_commit_go   = w_wait_done;
      assign w_commit_wr   = req_wr_q;
      assign w_commit_idx  = req_idx_q;
      assign w_commit_data = req_data_q;
      assign unused_req    = 1'b0;
    end
  endgenerate

  // Gating with rst_n keeps a reset that overlaps the commit edge from writing.
  assign w_mem_we = w_commit_go && w_commit_wr && rst_n;

  // State register plus counter, captured request and load-result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= C_ST_IDLE;
      count_q    <= 4'd0;
      req_wr_q   <= 1'b0;
      req_idx_q  <= '0;
      req_data_q <= 16'h0000;
      data_out_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      req_wr_q   <= req_wr_d;
      req_idx_q  <= req_idx_d;
      req_data_q <= req_data_d;
      data_out_q <= data_out_d;
    end
  end

  // Array write port: a store lands on the edge that enters RESP
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[w_commit_idx] <= w_commit_data;
    end
  end

  // Next-state logic: IDLE/RESP accept into WAIT (or straight to RESP), WAIT counts down
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_IDLE, C_ST_RESP: begin
        if (w_accept) begin
          state_d = C_DIRECT ? C_ST_RESP : C_ST_WAIT;
        end else begin
          state_d = C_ST_IDLE;
        end
      end
      C_ST_WAIT: begin
        if (count_q == 4'd0) begin
          state_d = C_ST_RESP;
        end else begin
          state_d = C_ST_WAIT;
        end
      end
      default: state_d = C_ST_IDLE;
    endcase
  end

  // Datapath: capture on accept, count down in WAIT, load result on commit
  always_comb begin
    count_d    = count_q;
    req_wr_d   = req_wr_q;
    req_idx_d  = req_idx_q;
    req_data_d = req_data_q;
    data_out_d = data_out_q;

    if (w_accept) begin
      count_d    = C_WAIT_INIT;
      req_wr_d   = wr;
      req_idx_d  = w_in_idx;
      req_data_d = data_in;
    end else if ((state_q == C_ST_WAIT) && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end

    // Stores leave the previous load result on data_out.
    if (w_commit_go && !w_commit_wr) begin
      data_out_d = mem_q[w_commit_idx];
    end
  end

  // Outputs decoded purely from state so nothing leaks out of non-RESP states
  always_comb begin
    busy       = (state_q == C_ST_WAIT);
    data_valid = (state_q == C_ST_RESP);
    data_out   = data_out_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Scoreboard bench for mem_responder. Two instances: latency 4
//             with a 15-bit word index, and latency 1 with an 8-bit index so
//             high address bits alias.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;
  localparam int AW0  = 15;
  localparam int AW1  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en     [2];
  logic        wr_s   [2];
  logic [15:0] addr_s [2];
  logic [15:0] din    [2];
  logic [15:0] dout_s [2];
  logic        dv_s   [2];
  logic        busy_s [2];

  typedef struct {
    int          d;
    bit          is_wr;
    int          key;
    logic [15:0] dout;
    int          due;
    logic [15:0] old_val;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] mmem [int];
  logic [15:0] last_dout [2];
  int          la [2];
  int          free_at [2];
  bit          has [2];
  int          edge_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  mem_responder #(.ADDR_W(AW0), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .wr(wr_s[0]), .addr(addr_s[0]),
    .data_in(din[0]), .data_out(dout_s[0]), .data_valid(dv_s[0]), .busy(busy_s[0])
  );

  mem_responder #(.ADDR_W(AW1), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .wr(wr_s[1]), .addr(addr_s[1]),
    .data_in(din[1]), .data_out(dout_s[1]), .data_valid(dv_s[1]), .busy(busy_s[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int idx_of(input int d, input logic [15:0] a);
    return (d == 0) ? int'(a[15:1]) : int'(a[8:1]);
  endfunction

  function automatic logic [15:0] mk_addr(input int d, input int i);
    logic [14:0] p;
    logic [15:0] a;
    case (i)
      0:       p = 15'h0008;
      1:       p = 15'h0010;
      2:       p = 15'h0003;
      3:       p = 15'h7FFF;
      4:       p = 15'h1234;
      5:       p = 15'h0000;
      6:       p = 15'h4001;
      default: p = 15'h0100;
    endcase
    if (d == 0) a = {p, 1'($urandom_range(0, 1))};
    else        a = {7'($urandom), p[7:0], 1'($urandom_range(0, 1))};
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a request at a negedge and hold it until the model says the
  // responder can take it; optionally scramble the inputs while it is busy.
  task automatic issue(input int d, input bit w, input logic [15:0] a,
                       input logic [15:0] dat, input bit noise);
    exp_t ent;
    int   c;
    int   key;
    while (edge_cnt + 1 < free_at[d]) begin
      if (noise) begin
        en[d]     = 1'($urandom_range(0, 1));
        wr_s[d]   = 1'($urandom_range(0, 1));
        addr_s[d] = 16'($urandom);
        din[d]    = 16'($urandom);
      end else begin
        en[d] = 1'b1; wr_s[d] = w; addr_s[d] = a; din[d] = dat;
      end
      @(negedge clk); #2;
    end
    en[d] = 1'b1; wr_s[d] = w; addr_s[d] = a; din[d] = dat;
    @(posedge clk); #1;
    c   = edge_cnt;
    key = d * 65536 + idx_of(d, a);
    ent.d       = d;
    ent.is_wr   = w;
    ent.key     = key;
    ent.due     = c + lat_of(d) - 1;
    ent.old_val = 16'h0000;
    if (w) begin
      ent.old_val = mmem.exists(key) ? mmem[key] : 16'h0000;
      ent.dout    = last_dout[d];
      mmem[key]   = dat;
    end else begin
      ent.dout     = mmem[key];
      last_dout[d] = ent.dout;
    end
    sb.push_back(ent);
    la[d]      = c;
    has[d]     = 1'b1;
    free_at[d] = c + lat_of(d);
    @(negedge clk); #2;
    en[d] = 1'b0;
  endtask

  // Everything in flight is lost on reset: undo uncommitted stores in the model.
  task automatic model_reset();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].is_wr) mmem[sb[i].key] = sb[i].old_val;
    end
    sb.delete();
    for (int d = 0; d < 2; d++) begin
      last_dout[d] = 16'h0000;
      has[d]       = 1'b0;
      free_at[d]   = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_busy"},  32'(busy_s[d]), 32'd0);
      chk({tag, "_valid"}, 32'(dv_s[d]),   32'd0);
      chk({tag, "_dout"},  32'(dout_s[d]), 32'd0);
    end
  endtask

  // Store to 0x0020, then pull reset low through its commit edge.
  task automatic reset_abort();
    int c;
    issue(0, 1'b1, 16'h0020, 16'h1234, 1'b0);
    c = la[0];
    while (edge_cnt < c + LAT0 - 2) begin
      @(negedge clk); #2;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    model_reset();
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compares handshake outputs with the model every cycle and pops
  // the scoreboard on each data_valid pulse.
  always @(negedge clk) begin
    int e;
    int k;
    bit bexp;
    bit vexp;
    for (int d = 0; d < 2; d++) begin
      e    = edge_cnt;
      bexp = has[d] && (e >= la[d]) && (e <= la[d] + lat_of(d) - 2);
      vexp = has[d] && (e == la[d] + lat_of(d) - 1);
      chk(d == 0 ? "busy0" : "busy1", 32'(busy_s[d]), 32'(bexp));
      chk(d == 0 ? "valid0" : "valid1", 32'(dv_s[d]), 32'(vexp));
      if (dv_s[d] === 1'b1) begin
        k = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (k < 0 && sb[i].d == d) k = i;
        end
        if (k < 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp dut%0d: got data_valid with empty scoreboard (t=%0t)", d, $time);
        end else begin
          chk(d == 0 ? "resp_edge0" : "resp_edge1", 32'(e), 32'(sb[k].due));
          chk(d == 0 ? "data_out0" : "data_out1", 32'(dout_s[d]), 32'(sb[k].dout));
          sb.delete(k);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 16'h0; din[i] = 16'h0;
      last_dout[i] = 16'h0; la[i] = 0; free_at[i] = 0; has[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("init_reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #2;

    // Give every pool location a known value in both instances.
    for (int dd = 0; dd < 2; dd++) begin
      for (int i = 0; i < 8; i++) begin
        issue(dd, 1'b1, mk_addr(dd, i), 16'($urandom), 1'b0);
      end
    end

    // Store/load pair back-to-back, then a store presented under noise.
    issue(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    issue(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    issue(0, 1'b1, 16'h0020, 16'hC3C3, 1'b1);
    reset_abort();
    @(negedge clk); #2;
    issue(0, 1'b0, 16'h0020, 16'hFFFF, 1'b0);

    // Single-cycle instance: bit 0 and high bits alias onto the same word.
    issue(1, 1'b1, 16'h0011, 16'hA11A, 1'b0);
    issue(1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    issue(1, 1'b0, 16'hFE11, 16'h0000, 1'b0);

    for (int n = 0; n < 200; n++) begin
      d = int'($urandom_range(0, 1));
      issue(d, 1'($urandom_range(0, 1)), mk_addr(d, int'($urandom_range(0, 7))),
            16'($urandom), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); #2;
      end
    end

    while (edge_cnt < free_at[0] + 2 || edge_cnt < free_at[1] + 2) begin
      @(negedge clk); #2;
    end
    chk("drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
